// File: rtl/axi_lite_pkg.sv
// Shared encodings for the two-master AXI-lite arbiter: FSM states, response codes, master IDs.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

endpackage

// File: rtl/axi_arb_pick.sv
// Collision resolution between instruction and data masters.
// ARB_RR_EN: round-robin with a last_grant register; otherwise data master wins.
module axi_arb_pick
  import axi_lite_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic winner
);

  logic collide_pick_s;

`ifdef ARB_RR_EN
  logic last_grant_r;

  // Remember who was granted so the other master wins the next collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= MST_I;
    end else if (take) begin
      last_grant_r <= winner;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign collide_pick_s = ~last_grant_r;
`else
  logic unused_s;
  assign unused_s       = &{1'b0, clk, rst_n, take};
  assign collide_pick_s = MST_D;
`endif

  // Winner select: a lone requester wins outright.
  always_comb begin
    winner = MST_I;
    if (i_req && d_req) begin
      winner = collide_pick_s;
    end else if (d_req) begin
      winner = MST_D;
    end else begin
      winner = MST_I;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (instruction read-only, data read/write) to one-slave AXI-lite arbiter.
// Optional ARB_RR_EN selects round-robin collision handling instead of data priority.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   i_araddr_i,
  input  logic                    i_arvalid_i,
  output logic                    i_arready_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic [1:0]              i_rresp_o,
  output logic                    i_rvalid_o,
  input  logic                    i_rready_i,
  input  logic [ADDR_WIDTH-1:0]   d_araddr_i,
  input  logic                    d_arvalid_i,
  output logic                    d_arready_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic [1:0]              d_rresp_o,
  output logic                    d_rvalid_o,
  input  logic                    d_rready_i,
  input  logic [ADDR_WIDTH-1:0]   d_awaddr_i,
  input  logic                    d_awvalid_i,
  output logic                    d_awready_o,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
  input  logic                    d_wvalid_i,
  output logic                    d_wready_o,
  output logic [1:0]              d_bresp_o,
  output logic                    d_bvalid_o,
  input  logic                    d_bready_i,
  output logic [ADDR_WIDTH-1:0]   s_araddr_o,
  output logic                    s_arvalid_o,
  input  logic                    s_arready_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic [1:0]              s_rresp_i,
  input  logic                    s_rvalid_i,
  output logic                    s_rready_o,
  output logic [ADDR_WIDTH-1:0]   s_awaddr_o,
  output logic                    s_awvalid_o,
  input  logic                    s_awready_i,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  output logic                    s_wvalid_o,
  input  logic                    s_wready_i,
  input  logic [1:0]              s_bresp_i,
  input  logic                    s_bvalid_i,
  output logic                    s_bready_o
);

  arb_state_e state_r, next_state_s;
  logic       ar_done_r, aw_done_r, w_done_r;
  logic       i_req_s, d_req_s, take_s, winner_s;

  assign i_req_s = i_arvalid_i;
  assign d_req_s = d_arvalid_i | d_awvalid_i;
  assign take_s  = (state_r == IDLE) & (i_req_s | d_req_s);

  axi_arb_pick u_pick (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .i_req  (i_req_s),
    .d_req  (d_req_s),
    .take   (take_s),
    .winner (winner_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: grant from IDLE, release on the response handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          if (winner_s == MST_I) begin
            next_state_s = I_RD;
          end else if (d_arvalid_i) begin
            next_state_s = D_RD;
          end else begin
            next_state_s = D_WR;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      I_RD: begin
        if (s_rvalid_i && i_rready_i) next_state_s = IDLE;
        else                          next_state_s = I_RD;
      end
      D_RD: begin
        if (s_rvalid_i && d_rready_i) next_state_s = IDLE;
        else                          next_state_s = D_RD;
      end
      D_WR: begin
        if (s_bvalid_i && d_bready_i) next_state_s = IDLE;
        else                          next_state_s = D_WR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Per-channel done flags give exactly one address/data handshake per transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (next_state_s == IDLE) begin
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      ar_done_r <= ar_done_r | (s_arvalid_o & s_arready_i);
      aw_done_r <= aw_done_r | (s_awvalid_o & s_awready_i);
      w_done_r  <= w_done_r  | (s_wvalid_o  & s_wready_i);
    end
  end

  // Pass-through muxing for the granted master; everything else held at 0.
  always_comb begin
    i_arready_o = 1'b0;
    i_rdata_o   = {DATA_WIDTH{1'b0}};
    i_rresp_o   = 2'b00;
    i_rvalid_o  = 1'b0;
    d_arready_o = 1'b0;
    d_rdata_o   = {DATA_WIDTH{1'b0}};
    d_rresp_o   = 2'b00;
    d_rvalid_o  = 1'b0;
    d_awready_o = 1'b0;
    d_wready_o  = 1'b0;
    d_bresp_o   = 2'b00;
    d_bvalid_o  = 1'b0;
    s_araddr_o  = {ADDR_WIDTH{1'b0}};
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_awaddr_o  = {ADDR_WIDTH{1'b0}};
    s_awvalid_o = 1'b0;
    s_wdata_o   = {DATA_WIDTH{1'b0}};
    s_wstrb_o   = {(DATA_WIDTH/8){1'b0}};
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    case (state_r)
      I_RD: begin
        s_araddr_o  = i_araddr_i;
        s_arvalid_o = i_arvalid_i & ~ar_done_r;
        i_arready_o = s_arready_i & ~ar_done_r;
        i_rdata_o   = s_rdata_i;
        i_rresp_o   = s_rresp_i;
        i_rvalid_o  = s_rvalid_i;
        s_rready_o  = i_rready_i;
      end
      D_RD: begin
        s_araddr_o  = d_araddr_i;
        s_arvalid_o = d_arvalid_i & ~ar_done_r;
        d_arready_o = s_arready_i & ~ar_done_r;
        d_rdata_o   = s_rdata_i;
        d_rresp_o   = s_rresp_i;
        d_rvalid_o  = s_rvalid_i;
        s_rready_o  = d_rready_i;
      end
      D_WR: begin
        s_awaddr_o  = d_awaddr_i;
        s_awvalid_o = d_awvalid_i & ~aw_done_r;
        d_awready_o = s_awready_i & ~aw_done_r;
        s_wdata_o   = d_wdata_i;
        s_wstrb_o   = d_wstrb_i;
        s_wvalid_o  = d_wvalid_i & ~w_done_r;
        d_wready_o  = s_wready_i & ~w_done_r;
        d_bresp_o   = s_bresp_i;
        d_bvalid_o  = s_bvalid_i;
        s_bready_o  = d_bready_i;
      end
      default: begin
        s_arvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter; expectations follow ARB_RR_EN when defined.
module tb_axi_lite_arbiter;

  logic        clk, rst_n;
  logic [31:0] i_araddr;  logic i_arvalid, i_arready;
  logic [31:0] i_rdata;   logic [1:0] i_rresp; logic i_rvalid, i_rready;
  logic [31:0] d_araddr;  logic d_arvalid, d_arready;
  logic [31:0] d_rdata;   logic [1:0] d_rresp; logic d_rvalid, d_rready;
  logic [31:0] d_awaddr;  logic d_awvalid, d_awready;
  logic [31:0] d_wdata;   logic [3:0] d_wstrb; logic d_wvalid, d_wready;
  logic [1:0]  d_bresp;   logic d_bvalid, d_bready;
  logic [31:0] s_araddr;  logic s_arvalid, s_arready;
  logic [31:0] s_rdata;   logic [1:0] s_rresp; logic s_rvalid, s_rready;
  logic [31:0] s_awaddr;  logic s_awvalid, s_awready;
  logic [31:0] s_wdata;   logic [3:0] s_wstrb; logic s_wvalid, s_wready;
  logic [1:0]  s_bresp;   logic s_bvalid, s_bready;

  int checks   = 0;
  int failures = 0;
  int aw_hs    = 0;
  int w_hs     = 0;
  int aw0, w0;

  logic d_side_or, all_or;
  assign d_side_or = |{d_arready, d_rdata, d_rresp, d_rvalid, d_awready, d_wready, d_bresp, d_bvalid};
  assign all_or    = d_side_or | (|{i_arready, i_rdata, i_rresp, i_rvalid, s_araddr, s_arvalid,
                                    s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready});

  axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .i_araddr_i(i_araddr), .i_arvalid_i(i_arvalid), .i_arready_o(i_arready),
    .i_rdata_o(i_rdata), .i_rresp_o(i_rresp), .i_rvalid_o(i_rvalid), .i_rready_i(i_rready),
    .d_araddr_i(d_araddr), .d_arvalid_i(d_arvalid), .d_arready_o(d_arready),
    .d_rdata_o(d_rdata), .d_rresp_o(d_rresp), .d_rvalid_o(d_rvalid), .d_rready_i(d_rready),
    .d_awaddr_i(d_awaddr), .d_awvalid_i(d_awvalid), .d_awready_o(d_awready),
    .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb), .d_wvalid_i(d_wvalid), .d_wready_o(d_wready),
    .d_bresp_o(d_bresp), .d_bvalid_o(d_bvalid), .d_bready_i(d_bready),
    .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
    .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
    .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
    .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave-side handshake counters.
  always @(posedge clk) begin
    if (s_awvalid && s_awready) aw_hs <= aw_hs + 1;
    if (s_wvalid && s_wready)   w_hs  <= w_hs + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_araddr = 32'h0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = 32'h0; d_arvalid = 1'b0; d_rready = 1'b0;
    d_awaddr = 32'h0; d_awvalid = 1'b0;
    d_wdata  = 32'h0; d_wstrb = 4'h0; d_wvalid = 1'b0; d_bready = 1'b0;
    s_arready = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
  endtask

  initial begin
    logic exp_d;
    clear_inputs();
    rst_n = 1'b0;
    i_arvalid = 1'b1;
    #1 check_eq("rst_outs_zero", {63'h0, all_or}, 64'h0);
    tick(); tick();
    i_arvalid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Instruction read at 0x8000_0000
    i_araddr = 32'h8000_0000; i_arvalid = 1'b1; i_rready = 1'b1;
    #1 check_eq("ird_idle_arvalid", {63'h0, s_arvalid}, 64'h0);
    tick();
    s_arready = 1'b1;
    #1 check_eq("ird_s_arvalid", {63'h0, s_arvalid}, 64'h1);
    check_eq("ird_s_araddr", {32'h0, s_araddr}, 64'h8000_0000);
    check_eq("ird_i_arready", {63'h0, i_arready}, 64'h1);
    check_eq("ird_dside", {63'h0, d_side_or}, 64'h0);
    tick();
    s_arready = 1'b0;
    #1 check_eq("ird_ar_done", {63'h0, s_arvalid}, 64'h0);
    tick();
    i_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    #1 check_eq("ird_rvalid", {63'h0, i_rvalid}, 64'h1);
    check_eq("ird_rdata", {32'h0, i_rdata}, 64'h0000_0413);
    check_eq("ird_rresp", {62'h0, i_rresp}, 64'h0);
    check_eq("ird_s_rready", {63'h0, s_rready}, 64'h1);
    check_eq("ird_dside_r", {63'h0, d_side_or}, 64'h0);
    tick();
    s_rvalid = 1'b0; s_rdata = 32'h0;
    #1 check_eq("ird_back_idle", {63'h0, all_or}, 64'h0);

    // Same-cycle instruction and data read requests, four grants
    i_araddr = 32'h0000_1000; d_araddr = 32'h0000_2000;
    i_arvalid = 1'b1; d_arvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1 check_eq("col_idle", {63'h0, s_arvalid}, 64'h0);
      tick();
      s_arready = 1'b1;
      #1 check_eq("col_addr", {32'h0, s_araddr}, exp_d ? 64'h2000 : 64'h1000);
      check_eq("col_arready", {62'h0, i_arready, d_arready}, {62'h0, ~exp_d, exp_d});
      tick();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h100 + k;
      #1 check_eq("col_rvalid", {62'h0, i_rvalid, d_rvalid}, {62'h0, ~exp_d, exp_d});
      tick();
      s_rvalid = 1'b0;
    end
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    tick();

    // Data write, W handshake one cycle before AW
    d_awaddr = 32'h8000_0100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    d_awvalid = 1'b1; d_wvalid = 1'b1; d_bready = 1'b1;
    aw0 = aw_hs; w0 = w_hs;
    #1 check_eq("wr_idle_awvalid", {63'h0, s_awvalid}, 64'h0);
    tick();
    s_wready = 1'b1;
    #1 check_eq("wr_s_awvalid", {63'h0, s_awvalid}, 64'h1);
    check_eq("wr_s_awaddr", {32'h0, s_awaddr}, 64'h8000_0100);
    check_eq("wr_s_wvalid", {63'h0, s_wvalid}, 64'h1);
    check_eq("wr_s_wdata", {32'h0, s_wdata}, 64'hDEAD_BEEF);
    check_eq("wr_s_wstrb", {60'h0, s_wstrb}, 64'h3);
    check_eq("wr_readies", {62'h0, d_awready, d_wready}, 64'h1);
    tick();
    s_awready = 1'b1;
    #1 check_eq("wr_w_done", {62'h0, s_wvalid, d_wready}, 64'h0);
    check_eq("wr_awready", {63'h0, d_awready}, 64'h1);
    tick();
    d_awvalid = 1'b0; d_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00;
    #1 check_eq("wr_aw_done", {63'h0, s_awvalid}, 64'h0);
    check_eq("wr_bvalid", {63'h0, d_bvalid}, 64'h1);
    check_eq("wr_bready", {63'h0, s_bready}, 64'h1);
    tick();
    s_bvalid = 1'b0;
    #1 check_eq("wr_aw_count", aw_hs - aw0, 64'h1);
    check_eq("wr_w_count", w_hs - w0, 64'h1);
    check_eq("wr_back_idle", {63'h0, all_or}, 64'h0);

    // Data read answered with SLVERR
    d_araddr = 32'h8000_0200; d_arvalid = 1'b1; d_rready = 1'b1;
    tick();
    s_arready = 1'b1;
    #1 check_eq("err_arready", {63'h0, d_arready}, 64'h1);
    tick();
    d_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rresp = 2'b10; s_rdata = 32'h55;
    #1 check_eq("err_rresp", {62'h0, d_rresp}, 64'h2);
    check_eq("err_rvalid", {62'h0, i_rvalid, d_rvalid}, 64'h1);
    tick();
    s_rvalid = 1'b0; s_rresp = 2'b00;
    #1 check_eq("err_back_idle", {63'h0, all_or}, 64'h0);

    // Reset mid-write after the AW handshake
    d_awaddr = 32'h8000_0300; d_awvalid = 1'b1; d_wvalid = 1'b1; d_bready = 1'b1;
    tick();
    s_awready = 1'b1;
    #1 check_eq("rstw_grant", {63'h0, s_awvalid}, 64'h1);
    tick();
    d_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b1; s_bvalid = 1'b1;
    rst_n = 1'b0;
    #1 check_eq("rstw_outs_zero", {63'h0, all_or}, 64'h0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    i_araddr = 32'h8000_0004; i_arvalid = 1'b1; i_rready = 1'b1;
    #1 check_eq("post_rst_idle", {63'h0, s_arvalid}, 64'h0);
    tick();
    s_arready = 1'b1;
    #1 check_eq("post_rst_grant", {63'h0, s_arvalid}, 64'h1);
    check_eq("post_rst_addr", {32'h0, s_araddr}, 64'h8000_0004);
    tick();
    i_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    #1 check_eq("post_rst_rvalid", {63'h0, i_rvalid}, 64'h1);
    tick();
    s_rvalid = 1'b0;
    d_awvalid = 1'b1; d_awaddr = 32'h8000_0400;
    tick();
    #1 check_eq("post_rst_awvalid", {63'h0, s_awvalid}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI-lite arbiter that shares a single memory port between the instruction-fetch path and the load/store path of the multi-cycle RISC-V core. The instruction master is read-only (AR/R); the data master uses all five channels. The arbiter sits between the IFU/BDU fetch interface, the EXU/LSU data interface and one AXI-lite memory slave. It grants one whole transaction at a time and holds the grant until the response handshake completes.

## Interface
- ADDR_WIDTH, 32, address width on all channels
- DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- i_araddr_i / i_arvalid_i / i_arready_o  in/in/out  ADDR_WIDTH/1/1  instruction AR channel
- i_rdata_o / i_rresp_o / i_rvalid_o / i_rready_i  out/out/out/in  DATA_WIDTH/2/1/1  instruction R channel
- d_araddr_i / d_arvalid_i / d_arready_o  in/in/out  ADDR_WIDTH/1/1  data AR channel
- d_rdata_o / d_rresp_o / d_rvalid_o / d_rready_i  out/out/out/in  DATA_WIDTH/2/1/1  data R channel
- d_awaddr_i / d_awvalid_i / d_awready_o  in/in/out  ADDR_WIDTH/1/1  data AW channel
- d_wdata_i / d_wstrb_i / d_wvalid_i / d_wready_o  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  data W channel
- d_bresp_o / d_bvalid_o / d_bready_i  out/out/in  2/1/1  data B channel
- s_* (araddr, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready)  mirrored directions  slave-side channels

## Operation
- States: IDLE, I_RD, D_RD, D_WR. Reset state is IDLE.
- In IDLE, requests are i_arvalid_i, d_arvalid_i and d_awvalid_i. Transitions:
  - Only the instruction master requests: go to I_RD.
  - Only the data master requests: go to D_RD if d_arvalid_i is high, otherwise D_WR. Data read beats data write when both are high.
  - Both masters request: resolve per Configuration.
- In IDLE, every s_*valid, every s_*ready and every master-side ready/valid output is 0.
- Granted state: the granted master's channels pass through combinationally to/from s_*. The non-granted master sees all ready/valid outputs at 0.
- Per-channel done flags (ar_done, aw_done, w_done) set on the handshake and cleared on return to IDLE. Once a flag is set, that channel's s_*valid and master ready are forced to 0, so each channel sees exactly one handshake per transaction.
- I_RD and D_RD exit to IDLE on s_rvalid_i && rready.
- D_WR: AW and W are accepted in either order or together. Exit to IDLE on s_bvalid_i && d_bready_i. An early B before both AW and W are done is still forwarded and still ends the transaction.
- rresp/bresp are forwarded unmodified, including SLVERR. The arbiter never generates responses.
- Unused s_* data/address outputs drive 0 when not granted.
- Reset assertion mid-transaction forces IDLE and zeroes all done flags and last_grant. The outputs fall asynchronously. An in-flight slave transaction is abandoned; the slave is reset by the same rst_i.

## Timing
- Grant latency: a request first seen in IDLE at cycle N is granted at N+1, so s_arvalid/s_awvalid rise at N+1. Masters hold valid until the handshake, per AXI.
- After the grant there are zero added cycles; all channels are combinational pass-through.
- Turnaround: response handshake at cycle M, IDLE at M+1, next grant at M+2. There is one bubble cycle between back-to-back transactions.
- A master's valid that drops before its grant is not a protocol-legal case; the arbiter then returns to IDLE only through the response rule.

## Configuration
- ARB_RR_EN defined: round-robin. A 1-bit last_grant register records the master granted last (reset value: instruction). On collision, the other master wins.
- ARB_RR_EN undefined: fixed priority; the data master always wins on collision. There is no last_grant register.

## Structure
- Shared header axi_lite_pkg holds:
  - State encodings (IDLE=2'd0, I_RD=2'd1, D_RD=2'd2, D_WR=2'd3).
  - Response codes (OKAY=2'b00, SLVERR=2'b10).
  - Master IDs (MST_I=1'b0, MST_D=1'b1).
- Sub-module axi_arb_pick: collision resolution plus the last_grant register under ARB_RR_EN. The FSM, done flags and muxing stay in axi_lite_arbiter.

## Test plan
- Instruction read at 0x8000_0000: slave arready at cycle 1, rdata 0x0000_0413 at cycle 3 → i_rdata_o=0x0000_0413, i_rresp_o=OKAY, state IDLE at cycle 4; data-side outputs stay 0 throughout.
- Data write 0x8000_0100, wdata 0xDEAD_BEEF, wstrb 4'b0011, W one cycle before AW → exactly one AW and one W handshake on the slave, d_bvalid_o follows s_bvalid_i.
- Same-cycle i_arvalid_i and d_arvalid_i, repeated 4 times:
  - ARB_RR_EN defined: grant order D,I,D,I.
  - ARB_RR_EN undefined: data is granted first every time.
- Slave returns rresp=SLVERR on a data read → d_rresp_o=2'b10, and the arbiter returns to IDLE normally.
- rst_i asserted low in D_WR after the AW handshake, before B → every output is 0 immediately. After release, a new instruction read is granted one cycle after its request.
